// File: rtl/xor_nn_pkg.sv
// xor_nn_pkg: constants and Q8.8 data type shared by the
// XOR classifier host and its tracking pipe.
package xor_nn_pkg;

   typedef logic signed [15:0] q8_t;

   localparam q8_t Q_ONE  = 16'sh0100;
   localparam q8_t Q_ZERO = 16'sh0000;
   localparam int  NN_LAT = 6;

endpackage

// File: rtl/xor_nn_host_if.sv
// xor_nn_host_if: sample-in and result-out valid/ready streams
// between the sample source/consumer and the classifier host.
interface xor_nn_host_if #(
   parameter int TAG_W = 4
);
   import xor_nn_pkg::*;

   logic             in_valid;
   logic             in_ready;
   q8_t              in_x1;
   q8_t              in_x2;
   logic             out_valid;
   logic             out_ready;
   logic             out_class;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_x1, in_x2, out_ready,
      input  in_ready, out_valid, out_class, out_tag
   );

   modport slave (
      input  in_valid, in_x1, in_x2, out_ready,
      output in_ready, out_valid, out_class, out_tag
   );

endinterface

// File: rtl/xor_nn_track.sv
// xor_nn_track: valid + tag shadow of the network pipeline,
// advancing only on the same enable as the network stages.
module xor_nn_track
   import xor_nn_pkg::*;
#(
   parameter int LAT   = NN_LAT,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             vin,
   input  logic [TAG_W-1:0] tin,
   output logic             any,
   output logic             vlast,
   output logic [TAG_W-1:0] tlast
);

   logic [LAT-1:0]   vp;
   logic [TAG_W-1:0] tp [LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vp <= '0;
         for (int i = 0; i < LAT; i++) tp[i] <= '0;
      end else if (en) begin
         vp    <= {vp[LAT-2:0], vin};
         tp[0] <= tin;
         for (int i = 1; i < LAT; i++) tp[i] <= tp[i-1];
      end
   end

   assign any   = |vp;
   assign vlast = vp[LAT-1];
   assign tlast = tp[LAT-1];

endmodule

// File: rtl/xor_nn_host.sv
// xor_nn_host: feeds Q8.8 pairs into the fixed-latency XOR network
// and returns tagged class bits on a backpressured result stream.
module xor_nn_host
   import xor_nn_pkg::*;
#(
   parameter int LAT   = NN_LAT,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   xor_nn_host_if.slave     bus,
   output logic             nn_rst,
   output logic             nn_en,
   output q8_t              nn_x1,
   output q8_t              nn_x2,
   input  logic             nn_cl,
   output logic [2:0]       inflight,
   output logic             idle,
   output logic [CNT_W-1:0] done_cnt
);

   logic             vany;
   logic             vlast;
   logic [TAG_W-1:0] tlast;
   logic             stall;
   logic             acc;
   logic             load;
   logic             pop;
   logic [TAG_W-1:0] tag_cnt;
   logic             ovld;
   logic             ocls;
   logic [TAG_W-1:0] otag;
   logic [2:0]       infl;
   logic [CNT_W-1:0] dcnt;

   assign nn_rst = ~rst_n;

   // freeze the whole network only when a finished sample has nowhere to go
   assign stall = vlast && ovld && !bus.out_ready;
   assign nn_en = !stall && (bus.in_valid || vany);
   assign acc   = bus.in_valid && nn_en;
   assign load  = nn_en && vlast;
   assign pop   = ovld && bus.out_ready;

   assign bus.in_ready  = nn_en;
   assign bus.out_valid = ovld;
   assign bus.out_class = ocls;
   assign bus.out_tag   = otag;

   assign nn_x1 = acc ? bus.in_x1 : Q_ZERO;
   assign nn_x2 = acc ? bus.in_x2 : Q_ZERO;

   assign inflight = infl;
   assign idle     = (infl == 3'd0) && !ovld;
   assign done_cnt = dcnt;

   xor_nn_track #(
      .LAT   (LAT),
      .TAG_W (TAG_W)
   ) u_track (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (nn_en),
      .vin   (acc),
      .tin   (tag_cnt),
      .any   (vany),
      .vlast (vlast),
      .tlast (tlast)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_cnt <= '0;
         ovld    <= 1'b0;
         ocls    <= 1'b0;
         otag    <= '0;
         infl    <= 3'd0;
         dcnt    <= '0;
      end else begin
         if (acc) tag_cnt <= tag_cnt + TAG_W'(1);
         if (load) begin
            ovld <= 1'b1;
            ocls <= nn_cl;
            otag <= tlast;
         end else if (pop) begin
            ovld <= 1'b0;
         end
         if (pop) dcnt <= dcnt + CNT_W'(1);
         case ({acc, load})
            2'b10:   infl <= infl + 3'd1;
            2'b01:   infl <= infl - 3'd1;
            default: infl <= infl;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_nn_host.sv
// tb_xor_nn_host: drives the host against a behavioural XOR network
// and checks delivered results against an in-order expectation queue.
module tb_xor_nn_host;
   import xor_nn_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xor_nn_host_if #(.TAG_W(4)) bus ();

   logic        nn_rst, nn_en, nn_cl, idle;
   q8_t         nn_x1, nn_x2;
   logic [2:0]  inflight;
   logic [15:0] done_cnt;

   xor_nn_host #(
      .LAT   (6),
      .TAG_W (4),
      .CNT_W (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .nn_rst   (nn_rst),
      .nn_en    (nn_en),
      .nn_x1    (nn_x1),
      .nn_x2    (nn_x2),
      .nn_cl    (nn_cl),
      .inflight (inflight),
      .idle     (idle),
      .done_cnt (done_cnt)
   );

   function automatic logic ref_cls(input q8_t a, input q8_t b);
      return (a >= 16'sh0080) != (b >= 16'sh0080);
   endfunction

   // stand-in network: six enabled register stages of the XOR decision
   logic [5:0] net;
   always @(posedge clk) begin
      if (nn_rst) net <= '0;
      else if (nn_en) net <= {net[4:0], ref_cls(nn_x1, nn_x2)};
   end
   assign nn_cl = net[5];

   typedef struct {
      logic       cls;
      logic [3:0] tag;
      int         cyc;
   } item_t;

   item_t      expq[$];
   logic [3:0] tagq[$];
   int n_chk = 0, n_fail = 0;
   int n_acc = 0, n_del = 0, cyc = 0, max_infl = 0;
   logic [3:0] tagc = '0;
   logic in_rst = 1'b0, hold = 1'b0, hcls = 1'b0, lat_chk = 1'b0;
   logic exp_stall = 1'b0, obs_en = 1'b0, obs_ov = 1'b0;
   logic [3:0] htag = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic step(input logic r, input logic iv, input q8_t a,
                       input q8_t b, input logic ordy);
      logic  acc, pop;
      item_t e;
      @(negedge clk);
      rst_n         = r;
      bus.in_valid  = iv;
      bus.in_x1     = a;
      bus.in_x2     = b;
      bus.out_ready = ordy;
      #1;
      obs_en = nn_en;
      obs_ov = bus.out_valid;
      acc = 1'b0;
      pop = 1'b0;
      if (!r) begin
         check("nn_rst_on", 32'(nn_rst), 1);
         if (in_rst) begin
            check("rst_out_valid", 32'(bus.out_valid), 0);
            check("rst_inflight", 32'(inflight), 0);
            check("rst_idle", 32'(idle), 1);
            check("rst_done_cnt", 32'(done_cnt), 0);
         end
      end else begin
         check("nn_rst_off", 32'(nn_rst), 0);
         acc = iv && bus.in_ready;
         pop = bus.out_valid && ordy;
         if (hold) begin
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_tag", 32'(bus.out_tag), 32'(htag));
            check("hold_class", 32'(bus.out_class), 32'(hcls));
         end
         if (exp_stall) begin
            check("stall_nn_en", 32'(nn_en), 0);
            check("stall_in_ready", 32'(bus.in_ready), 0);
            check("stall_tag", 32'(bus.out_tag), 0);
         end
         check("nn_x1", 32'(nn_x1), acc ? 32'(a) : 0);
         check("nn_x2", 32'(nn_x2), acc ? 32'(b) : 0);
         check("inflight", 32'(inflight), 32'(n_acc - n_del - int'(bus.out_valid)));
         check("idle", 32'(idle), 32'(n_acc == n_del));
         check("done_cnt", 32'(done_cnt), 32'(n_del & 16'hffff));
         if (int'(inflight) > max_infl) max_infl = int'(inflight);
         if (pop) begin
            if (expq.size() == 0) begin
               check("pop_extra", 1, 0);
            end else begin
               e = expq.pop_front();
               check("out_class", 32'(bus.out_class), 32'(e.cls));
               check("out_tag", 32'(bus.out_tag), 32'(e.tag));
               if (lat_chk) check("latency", 32'(cyc - e.cyc), 7);
               tagq.push_back(bus.out_tag);
            end
         end
         hold = bus.out_valid && !ordy;
         htag = bus.out_tag;
         hcls = bus.out_class;
      end
      @(posedge clk);
      if (!r) begin
         expq.delete();
         tagc   = '0;
         n_acc  = 0;
         n_del  = 0;
         hold   = 1'b0;
         in_rst = 1'b1;
      end else begin
         in_rst = 1'b0;
         if (acc) begin
            expq.push_back('{ref_cls(a, b), tagc, cyc});
            tagc++;
            n_acc++;
         end
         if (pop) n_del++;
      end
      cyc++;
   endtask

   function automatic q8_t rnd_x();
      case ($urandom_range(0, 4))
         0:       return Q_ZERO;
         1:       return Q_ONE;
         2:       return 16'sh0080;
         3:       return 16'sh007f;
         default: return q8_t'($urandom);
      endcase
   endfunction

   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
   endtask

   q8_t tt_a [4];
   q8_t tt_b [4];
   int  sent, en_cnt, ov_cnt;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_x1     = Q_ZERO;
      bus.in_x2     = Q_ZERO;
      bus.out_ready = 1'b1;

      do_reset();

      // truth table, back to back
      tt_a = '{Q_ZERO, Q_ZERO, Q_ONE, Q_ONE};
      tt_b = '{Q_ZERO, Q_ONE, Q_ZERO, Q_ONE};
      lat_chk = 1'b1;
      tagq.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, tt_a[i], tt_b[i], 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
      check("tt_done_cnt", 32'(done_cnt), 4);
      check("tt_count", 32'(tagq.size()), 4);
      lat_chk = 1'b0;

      // backpressure while streaming 8 samples
      do_reset();
      tagq.delete();
      sent = 0;
      max_infl = 0;
      for (int c = 0; c < 30; c++) begin
         exp_stall = (c >= 7 && c <= 12);
         step(1'b1, sent < 8, rnd_x(), rnd_x(), !(c >= 7 && c <= 12));
         if (obs_en && sent < 8) sent++;
      end
      exp_stall = 1'b0;
      check("bp_count", 32'(tagq.size()), 8);
      for (int i = 0; i < 8 && i < tagq.size(); i++)
         check("bp_order", 32'(tagq[i]), 32'(i));
      check("bp_max_inflight", 32'(max_infl <= 6), 1);

      // single sample followed by bubbles
      do_reset();
      lat_chk = 1'b1;
      step(1'b1, 1'b1, Q_ONE, Q_ZERO, 1'b1);
      en_cnt = 0;
      ov_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
         en_cnt += int'(obs_en);
         ov_cnt += int'(obs_ov);
      end
      check("bub_en_cycles", 32'(en_cnt), 6);
      check("bub_ov_pulses", 32'(ov_cnt), 1);
      @(negedge clk);
      #1;
      check("bub_idle", 32'(idle), 1);
      check("bub_nn_en", 32'(nn_en), 0);

      // tag wrap over 18 samples
      do_reset();
      tagq.delete();
      for (int i = 0; i < 18; i++) step(1'b1, 1'b1, rnd_x(), rnd_x(), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
      check("wrap_count", 32'(tagq.size()), 18);
      if (tagq.size() == 18) begin
         check("wrap_t15", 32'(tagq[15]), 15);
         check("wrap_t16", 32'(tagq[16]), 0);
         check("wrap_t17", 32'(tagq[17]), 1);
      end
      lat_chk = 1'b0;

      // reset while samples are in flight
      step(1'b1, 1'b1, Q_ONE, Q_ZERO, 1'b1);
      step(1'b1, 1'b1, Q_ZERO, Q_ONE, 1'b1);
      step(1'b0, 1'b1, Q_ONE, Q_ONE, 1'b1);
      ov_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
         ov_cnt += int'(obs_ov);
      end
      check("mid_no_output", 32'(ov_cnt), 0);
      check("mid_inflight", 32'(inflight), 0);
      tagq.delete();
      step(1'b1, 1'b1, Q_ONE, Q_ZERO, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
      check("mid_count", 32'(tagq.size()), 1);
      if (tagq.size() == 1) check("mid_tag0", 32'(tagq[0]), 0);

      // random traffic with random backpressure
      max_infl = 0;
      for (int i = 0; i < 400; i++)
         step(1'b1, $urandom_range(0, 2) != 0, rnd_x(), rnd_x(),
              $urandom_range(0, 3) != 0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, Q_ZERO, Q_ZERO, 1'b1);
      check("rnd_drained", 32'(n_acc == n_del), 1);
      check("rnd_queue_empty", 32'(expq.size()), 0);
      check("rnd_max_inflight", 32'(max_infl <= 6), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
